// File: rtl/ins_mem_loader.sv
// Boot loader for the byte-addressed instruction memory: each streamed 32-bit word is written
// as four bytes, MSB first, while cpu_hold keeps the CPU in reset until the image is complete.
//   state   | meaning
//   IDLE    | after reset, no load requested yet
//   WAIT    | in_ready high, waiting for the next word
//   WRITE   | emitting the four bytes of the captured word
//   DONE    | load finished, CPU released
module ins_mem_loader #(
  parameter int MEM_BYTES = 64,
  parameter int CNT_W     = 6
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             err_overflow,
  output logic             cpu_hold
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [31:0]      base_al;
  logic [39:0]      range_end;
  logic             ovf;
  logic [31:0]      room;
  logic [CNT_W-1:0] cnt_clamped;
  logic [1:0]       nxt_idx;

  // Range check is done in 40 bits so a huge base_addr cannot wrap past the limit.
  always_comb begin
    base_al     = base_addr & ~32'd3;
    range_end   = {8'd0, base_al} + {{(38-CNT_W){1'b0}}, word_count, 2'b00};
    ovf         = range_end > {8'd0, MEM_LIMIT};
    room        = (base_al >= MEM_LIMIT) ? 32'd0 : ((MEM_LIMIT - base_al) >> 2);
    cnt_clamped = ovf ? CNT_W'(room) : word_count;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    nxt_idx     = byte_idx_q + 2'd1;
    case (state_q)
      S_IDLE, S_DONE: begin
        // busy while still in IDLE/DONE means a zero-length load: finish it now.
        if (busy_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (start) begin
          addr_d      = base_al;
          remaining_d = cnt_clamped;
          err_d       = ovf;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          if (cnt_clamped != '0) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_valid) begin
          word_d      = in_word;
          byte_idx_d  = 2'd0;
          state_d     = S_WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_word[31:24];
        end
      end
      S_WRITE: begin
        if (byte_idx_q == 2'd3) begin
          addr_d      = addr_q + 32'd4;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          byte_idx_d  = nxt_idx;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q + 32'(nxt_idx);
          mem_wdata_d = 8'(word_q >> (5'd24 - {nxt_idx, 3'b000}));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = (state_q == S_WAIT);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign cpu_hold     = ~done_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: a table of load requests plus hand-written sequences
// for reset during a write and start pulses arriving mid-load.
module tb_ins_mem_loader;
  localparam int MEM_BYTES = 64;
  localparam int CNT_W     = 6;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      in_word;
  logic             in_valid;
  logic             in_ready, mem_we, busy, done, err_overflow, cpu_hold;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_wdata;

  ins_mem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_overflow(err_overflow), .cpu_hold(cpu_hold)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wr_a[$];
  logic [7:0]  wr_d[$];
  bit          bad_addr = 1'b0;

  always @(negedge CLK) begin
    if (mem_we) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
      if (mem_addr >= 32'(MEM_BYTES)) bad_addr = 1'b1;
    end
  end

  typedef struct {
    logic [31:0]       base;
    int                cnt;
    logic [3:0][31:0]  w;
    int                stall;
    logic              exp_err;
    int                exp_bytes;
    logic [31:0]       exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_start(input logic [31:0] b, input int c);
    base_addr  = b;
    word_count = CNT_W'(c);
    start      = 1'b1;
    @(negedge CLK);
    start      = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall, input string tag);
    int n = 0;
    bit ok = 1'b1;
    in_valid = 1'b0;
    while (!in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    for (int s = 0; s < stall; s++) begin
      if (!in_ready || mem_we) ok = 1'b0;
      @(negedge CLK);
    end
    if (stall > 0) check({tag, " stall"}, 32'(ok), 32'd1);
    in_word  = w;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] first, input int n,
                             input logic [3:0][31:0] w);
    bit ok;
    logic [31:0] wv;
    logic [7:0]  ed;
    check({tag, " wr count"}, 32'(wr_a.size()), 32'(n));
    ok = (wr_a.size() == n);
    for (int k = 0; k < n && k < wr_a.size(); k++) begin
      wv = w[k/4];
      ed = 8'(wv >> (24 - 8*(k%4)));
      if (wr_a[k] !== first + 32'(k) || wr_d[k] !== ed) ok = 1'b0;
    end
    check({tag, " wr bytes"}, 32'(ok), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err_overflow), 32'd0);
    check({tag, " cpu_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    logic [7:0] t1_bytes[8];
    bit ok;
    string tag;

    vecs[0] = '{32'd0,  2, {32'h0, 32'h0, 32'h00221820, 32'h8C220004}, 0, 1'b0, 8, 32'd0};
    vecs[1] = '{32'd16, 2, {32'h0, 32'h0, 32'h55667788, 32'h11223344}, 3, 1'b0, 8, 32'd16};
    vecs[2] = '{32'd60, 3, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 0, 1'b1, 4, 32'd60};
    vecs[3] = '{32'd0,  0, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 1'b0, 0, 32'd0};
    vecs[4] = '{32'd62, 1, {32'h0, 32'h0, 32'h0, 32'h0BADC0DE}, 0, 1'b0, 4, 32'd60};
    vecs[5] = '{32'd64, 1, {32'h0, 32'h0, 32'h0, 32'h12345678}, 0, 1'b1, 0, 32'd0};
    vecs[6] = '{32'd48, 4, {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304}, 1, 1'b0, 16, 32'd48};
    t1_bytes = '{8'h8C, 8'h22, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};

    Reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; in_word = '0; in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle("reset");
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", 32'(mem_wdata), 32'd0);
    Reset = 1'b1;
    @(negedge CLK);
    check_idle("post reset");

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("v%0d", i);
      wr_a.delete();
      wr_d.delete();
      do_start(vecs[i].base, vecs[i].cnt);
      check({tag, " err"}, 32'(err_overflow), 32'(vecs[i].exp_err));
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " hold"}, 32'(cpu_hold), 32'd1);
      check({tag, " done clr"}, 32'(done), 32'd0);
      if (vecs[i].exp_bytes == 0) begin
        @(negedge CLK);
        check({tag, " done 2cyc"}, 32'(done), 32'd1);
      end else begin
        for (int j = 0; j < vecs[i].exp_bytes / 4; j++)
          send_word(vecs[i].w[j], vecs[i].stall, tag);
        wait_done(tag);
      end
      check({tag, " hold rel"}, 32'(cpu_hold), 32'd0);
      check({tag, " busy end"}, 32'(busy), 32'd0);
      check({tag, " err end"}, 32'(err_overflow), 32'(vecs[i].exp_err));
      check_bytes(tag, vecs[i].exp_first, vecs[i].exp_bytes, vecs[i].w);
      if (i == 0) begin
        ok = (wr_a.size() == 8);
        for (int k = 0; k < 8 && k < wr_a.size(); k++)
          if (wr_a[k] !== 32'(k) || wr_d[k] !== t1_bytes[k]) ok = 1'b0;
        check("t1 byte list", 32'(ok), 32'd1);
      end
    end

    // Reset asserted while byte 2 of a word is on the bus.
    wr_a.delete();
    wr_d.delete();
    do_start(32'd0, 2);
    send_word(32'hA5A5A5A5, 0, "rst");
    begin
      int n = 0;
      while (!(mem_we && mem_addr == 32'd2) && n < 20) begin
        @(negedge CLK);
        n++;
      end
    end
    check("rst byte2 seen", mem_addr, 32'd2);
    Reset = 1'b0;
    @(negedge CLK);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    Reset = 1'b1;
    wr_a.delete();
    wr_d.delete();
    in_valid = 1'b1;
    repeat (10) @(negedge CLK);
    in_valid = 1'b0;
    check("rst no writes", 32'(wr_a.size()), 32'd0);
    check("rst still idle", 32'(in_ready), 32'd0);

    // Start pulses during a load are ignored; a start from DONE relaunches.
    wr_a.delete();
    wr_d.delete();
    do_start(32'd0, 1);
    do_start(32'd60, 3);
    check("ign err", 32'(err_overflow), 32'd0);
    send_word(32'hA1B2C3D4, 0, "ign");
    do_start(32'd60, 3);
    wait_done("ign");
    check("ign err end", 32'(err_overflow), 32'd0);
    check_bytes("ign", 32'd0, 4, {32'h0, 32'h0, 32'h0, 32'hA1B2C3D4});
    wr_a.delete();
    wr_d.delete();
    do_start(32'd8, 1);
    check("restart done clr", 32'(done), 32'd0);
    check("restart hold", 32'(cpu_hold), 32'd1);
    send_word(32'hCAFEF00D, 0, "restart");
    wait_done("restart");
    check_bytes("restart", 32'd8, 4, {32'h0, 32'h0, 32'h0, 32'hCAFEF00D});

    check("addr in range", 32'(bad_addr), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
